// File: rtl/sensor_scan_pkg.sv
// sensor_scan_pkg: shared types, sizes and select mapping for the sensor scanner
package sensor_scan_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, COMMIT} state_e;
  localparam int N_CHAN = 8;
  localparam int SEL_W = 3;
  // mux select lines are wired MSB-first, so sel is the bit-reverse of the channel index
  function automatic logic [SEL_W-1:0] sel_of(input logic [SEL_W-1:0] k);
    return {k[0], k[1], k[2]};
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit
// ports: clk, rst_n (async active-low), d_i (async input), q_o (synchronized output)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff_q <= '0;
    else ff_q <= {ff_q[0], d_i};
  assign q_o = ff_q[1];
endmodule

// File: rtl/sensor_scan.sv
// sensor_scan: sweeps an external 8:1 sensor mux and publishes one byte per completed sweep
// ports: clk, rst_n (async active-low), en (scan enable), mux_out (async mux output),
//        sel (mux select), chan_val (last sweep), sweep_done/changed (commit pulses), busy
// SCAN_DEBOUNCE_EN: when defined, a bit only updates when two consecutive sweeps agree on it
module sensor_scan import sensor_scan_pkg::*; #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mux_out,
  output logic [SEL_W-1:0]  sel,
  output logic [N_CHAN-1:0] chan_val,
  output logic              sweep_done,
  output logic              changed,
  output logic              busy
);
  state_e            state_q;
  logic [SEL_W-1:0]  k_q;
  logic [7:0]        cnt_q;
  logic [N_CHAN-1:0] shadow_q;
  logic [N_CHAN-1:0] chan_d;
  logic              mux_s;
  sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d_i(mux_out), .q_o(mux_s));
`ifdef SCAN_DEBOUNCE_EN
  logic [N_CHAN-1:0] prev_q;
  assign chan_d = (shadow_q & ~(shadow_q ^ prev_q)) | (chan_val & (shadow_q ^ prev_q));
`else
  assign chan_d = shadow_q;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      sel        <= '0;
      chan_val   <= '0;
      sweep_done <= 1'b0;
      changed    <= 1'b0;
      busy       <= 1'b0;
`ifdef SCAN_DEBOUNCE_EN
      prev_q     <= '0;
`endif
    end else begin
      sweep_done <= 1'b0;
      changed    <= 1'b0;
      case (state_q)
        IDLE: if (en) begin
          state_q <= SETTLE;
          k_q     <= '0;
          cnt_q   <= '0;
          sel     <= sel_of(3'd0);
          busy    <= 1'b1;
        end
        SETTLE, SAMPLE: if (!en) begin
          // abort: drop the partial sweep, chan_val untouched
          state_q  <= IDLE;
          k_q      <= '0;
          cnt_q    <= '0;
          shadow_q <= '0;
          sel      <= '0;
          busy     <= 1'b0;
        end else if (state_q == SETTLE) begin
          cnt_q   <= (cnt_q == 8'(SETTLE_CYCLES - 1)) ? '0 : cnt_q + 8'd1;
          state_q <= (cnt_q == 8'(SETTLE_CYCLES - 1)) ? SAMPLE : SETTLE;
        end else begin
          shadow_q[k_q] <= mux_s;
          if (k_q == 3'(N_CHAN - 1)) state_q <= COMMIT;
          else begin
            k_q     <= k_q + 3'd1;
            sel     <= sel_of(k_q + 3'd1);
            state_q <= SETTLE;
          end
        end
        COMMIT: begin
          chan_val   <= chan_d;
          sweep_done <= 1'b1;
          changed    <= chan_d != chan_val;
`ifdef SCAN_DEBOUNCE_EN
          prev_q     <= shadow_q;
`endif
          k_q        <= '0;
          cnt_q      <= '0;
          sel        <= '0;
          busy       <= en;
          state_q    <= en ? SETTLE : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
